// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: default widths, 2-bit counter
// encodings, the BHT/BTB entry layout and a small counter helper.
package bp_pkg;

    localparam int BP_XLEN  = 32;
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

    // 2-bit saturating counter states; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    // One direct-mapped table entry (direction history plus branch target).
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        bp_ctr_e             ctr;
        logic [BP_XLEN-1:0]  target;
    } bp_entry_t;

    // A counter predicts taken in either of its two upper states.
    function automatic logic ctr_predicts_taken(input bp_ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic    taken,
    input  bp_ctr_e ctr,
    output bp_ctr_e ctr_next
);

    // Step one state towards the resolved direction, holding at either end.
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            SNT:     ctr_next = taken ? WNT : SNT;
            WNT:     ctr_next = taken ? WT  : SNT;
            WT:      ctr_next = taken ? ST  : WNT;
            ST:      ctr_next = taken ? ST  : WT;
            default: ctr_next = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage direct-mapped BHT/BTB lookup plus EX-stage resolution check and
// table training. Lookup and check are combinational; only the table is state.
// Optional build macro: BP_STATS_EN adds if_valid and three 32-bit event
// counters (stat_branches, stat_mispred, stat_hits).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN  = BP_XLEN,
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = XLEN - IDX_W - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
`ifdef BP_STATS_EN
    input  logic            if_valid,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred,
    output logic [31:0]     stat_hits,
`endif
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int              DEPTH   = 1 << IDX_W;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    bp_entry_t        table_r [DEPTH];

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] ex_tag_s;
    bp_entry_t        if_entry_s;
    bp_entry_t        ex_entry_s;
    bp_entry_t        new_entry_s;
    logic             if_hit_s;
    logic             ex_hit_s;
    logic             upd_en_s;
    logic             wr_en_s;
    bp_ctr_e          sat_ctr_s;

    assign if_idx_s   = if_pc[IDX_W+1:2];
    assign if_tag_s   = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx_s   = ex_pc[IDX_W+1:2];
    assign ex_tag_s   = ex_pc[XLEN-1:IDX_W+2];
    assign if_entry_s = table_r[if_idx_s];
    assign ex_entry_s = table_r[ex_idx_s];

    // IF lookup: a hit on a taken-leaning counter redirects fetch to the stored target.
    always_comb begin
        if_hit_s   = if_entry_s.valid && (if_entry_s.tag == if_tag_s);
        pred_taken = if_hit_s && ctr_predicts_taken(if_entry_s.ctr);
        if (pred_taken) begin
            pred_target = if_entry_s.target;
        end else begin
            pred_target = if_pc + PC_STEP;
        end
    end

    // EX check: wrong direction, or taken to a different target, forces a redirect.
    always_comb begin
        mispredict = ex_valid &&
                     ((ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target)));
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = ex_pc + PC_STEP;
        end
    end

    bp_sat_counter u_sat_counter (
        .taken    (ex_taken),
        .ctr      (ex_entry_s.ctr),
        .ctr_next (sat_ctr_s)
    );

    // Build the trained entry: hits move the counter, taken misses allocate,
    // and a jal always lands in the strongly-taken state.
    always_comb begin
        upd_en_s    = ex_valid && (ex_is_branch || ex_is_jal);
        ex_hit_s    = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
        wr_en_s     = upd_en_s && (ex_hit_s || ex_taken);
        new_entry_s = ex_entry_s;
        if (ex_hit_s) begin
            new_entry_s.ctr = ex_is_jal ? ST : sat_ctr_s;
            if (ex_taken) begin
                new_entry_s.target = ex_target;
            end else begin
                new_entry_s.target = ex_entry_s.target;
            end
        end else begin
            new_entry_s.valid  = 1'b1;
            new_entry_s.tag    = ex_tag_s;
            new_entry_s.ctr    = ex_is_jal ? ST : WT;
            new_entry_s.target = ex_target;
        end
    end

    // Table storage: reset invalidates every entry and parks counters at weakly-not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i].valid <= 1'b0;
                table_r[i].ctr   <= WNT;
            end
        end else if (wr_en_s) begin
            table_r[ex_idx_s] <= new_entry_s;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispred_r;
    logic [31:0] stat_hits_r;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r <= 32'd0;
            stat_mispred_r  <= 32'd0;
            stat_hits_r     <= 32'd0;
        end else begin
            if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (mispredict) begin
                stat_mispred_r <= stat_mispred_r + 32'd1;
            end
            if (if_valid && if_hit_s) begin
                stat_hits_r <= stat_hits_r + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;
    assign stat_hits     = stat_hits_r;
`else
    // jalr only matters to the event counters; it never trains the table.
    logic unused_jalr_s;
    assign unused_jalr_s = ex_is_jalr;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic        if_valid = 1'b1;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    logic [31:0] stat_hits;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          is_ex;
        logic        bit_exp;
        logic [31:0] word_exp;
    } exp_t;

    exp_t sb_q[$];

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
`ifdef BP_STATS_EN
        .if_valid       (if_valid),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred),
        .stat_hits      (stat_hits),
`endif
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued this cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (e.is_ex) begin
                if (mispredict !== e.bit_exp || redirect_pc !== e.word_exp) begin
                    errors++;
                    $display("FAIL %s: mispredict=%0b redirect_pc=%08h, expected mispredict=%0b redirect_pc=%08h",
                             e.name, mispredict, redirect_pc, e.bit_exp, e.word_exp);
                end
            end else begin
                if (pred_taken !== e.bit_exp || pred_target !== e.word_exp) begin
                    errors++;
                    $display("FAIL %s: pred_taken=%0b pred_target=%08h, expected pred_taken=%0b pred_target=%08h",
                             e.name, pred_taken, pred_target, e.bit_exp, e.word_exp);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pred(input string name, input logic tk, input logic [31:0] tgt);
        exp_t e;
        e.name = name; e.is_ex = 1'b0; e.bit_exp = tk; e.word_exp = tgt;
        sb_q.push_back(e);
    endtask

    task automatic exp_ex(input string name, input logic mis, input logic [31:0] redir);
        exp_t e;
        e.name = name; e.is_ex = 1'b1; e.bit_exp = mis; e.word_exp = redir;
        sb_q.push_back(e);
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0; ex_is_jal = 1'b0;
        ex_is_jalr = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    endtask

    // kind: 0 = non-branch, 1 = branch, 2 = jal, 3 = jalr
    task automatic ex_drive(input logic [31:0] pc, input int kind, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = pc;
        ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    // Idle EX cycle with a lookup of pc and its expected prediction.
    task automatic lookup(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        next_cycle();
        ex_idle();
        if_pc = pc;
        exp_pred(name, tk, tgt);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        if_pc = 32'h100;
        ex_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pred("reset_lookup", 1'b0, 32'h104);
        exp_ex("reset_no_mispredict", 1'b0, 32'h4);

        // Test 1: first taken branch mispredicts and allocates.
        next_cycle();
        if_pc = 32'h100;
        ex_drive(32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h104);
        exp_pred("t1_pre_update_lookup", 1'b0, 32'h104);
        exp_ex("t1_first_resolve", 1'b1, 32'h80);
        lookup("t1_after_alloc", 32'h100, 1'b1, 32'h80);

        // Test 2: saturate to ST, then two not-taken steps flip the prediction.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            ex_drive(32'h100, 1, 1'b1, 32'h80, 1'b1, 32'h80);
            exp_ex("t2_taken_correct", 1'b0, 32'h80);
        end
        next_cycle();
        ex_drive(32'h100, 1, 1'b0, 32'h80, 1'b1, 32'h80);
        exp_ex("t2_nt1_mispredict", 1'b1, 32'h104);
        lookup("t2_after_nt1", 32'h100, 1'b1, 32'h80);
        next_cycle();
        ex_drive(32'h100, 1, 1'b0, 32'h80, 1'b1, 32'h80);
        exp_ex("t2_nt2_mispredict", 1'b1, 32'h104);
        lookup("t2_after_nt2", 32'h100, 1'b0, 32'h104);

        // Test 3: jal allocates strongly taken, replacing the aliased 0x100 entry.
        next_cycle();
        ex_drive(32'h200, 2, 1'b1, 32'h400, 1'b0, 32'h204);
        exp_ex("t3_jal_first", 1'b1, 32'h400);
        lookup("t3_jal_lookup", 32'h200, 1'b1, 32'h400);
        lookup("t3_old_alias_gone", 32'h100, 1'b0, 32'h104);
        next_cycle();
        ex_drive(32'h200, 2, 1'b1, 32'h400, 1'b1, 32'h400);
        exp_ex("t3_jal_second", 1'b0, 32'h400);

        // Test 4: jalr always mispredicts and never writes the table.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ex_drive(32'h300, 3, 1'b1, 32'h500, 1'b0, 32'h304);
            exp_ex("t4_jalr_resolve", 1'b1, 32'h500);
        end
        lookup("t4_jalr_no_alloc", 32'h300, 1'b0, 32'h304);
        lookup("t4_jal_entry_kept", 32'h200, 1'b1, 32'h400);

        // Not-taken miss does not allocate; non-branch never writes.
        next_cycle();
        ex_drive(32'h104, 1, 1'b0, 32'h0, 1'b0, 32'h108);
        exp_ex("nt_miss_correct", 1'b0, 32'h108);
        lookup("nt_miss_no_alloc", 32'h104, 1'b0, 32'h108);
        next_cycle();
        ex_drive(32'h108, 0, 1'b1, 32'h700, 1'b0, 32'h10C);
        exp_ex("nonbranch_check", 1'b1, 32'h700);
        lookup("nonbranch_no_write", 32'h108, 1'b0, 32'h10C);

        // Test 5: aliasing at index 0 and same-cycle lookup/update.
        next_cycle();
        ex_drive(32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h104);
        exp_ex("t5_train_100", 1'b1, 32'h80);
        lookup("t5_lookup_100", 32'h100, 1'b1, 32'h80);
        next_cycle();
        if_pc = 32'h140;
        ex_drive(32'h140, 1, 1'b1, 32'h900, 1'b0, 32'h144);
        exp_pred("t5_same_cycle_140_miss", 1'b0, 32'h144);
        exp_ex("t5_resolve_140", 1'b1, 32'h900);
        lookup("t5_100_evicted", 32'h100, 1'b0, 32'h104);
        lookup("t5_140_hit", 32'h140, 1'b1, 32'h900);
        next_cycle();
        if_pc = 32'h140;
        ex_drive(32'h140, 1, 1'b1, 32'hA00, 1'b1, 32'h900);
        exp_pred("t5_same_cycle_old_target", 1'b1, 32'h900);
        exp_ex("t5_target_change", 1'b1, 32'hA00);
        lookup("t5_new_target", 32'h140, 1'b1, 32'hA00);

        // Test 6: reset beats a simultaneous taken update; then PC wrap.
        next_cycle();
        rst = 1'b1;
        ex_drive(32'h10C, 1, 1'b1, 32'h600, 1'b0, 32'h110);
        next_cycle();
        rst = 1'b0;
        ex_idle();
        if_pc = 32'h10C;
        exp_pred("t6_rst_wins_update", 1'b0, 32'h110);
        lookup("t6_140_cleared", 32'h140, 1'b0, 32'h144);
        lookup("t6_200_cleared", 32'h200, 1'b0, 32'h204);
        next_cycle();
        if_pc = 32'hFFFF_FFFC;
        ex_drive(32'hFFFF_FFFC, 1, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_pred("t6_if_wrap", 1'b0, 32'h0);
        exp_ex("t6_ex_wrap", 1'b0, 32'h0);
        next_cycle();
        ex_drive(32'h100, 1, 1'b1, 32'h80, 1'b0, 32'h104);
        ex_valid = 1'b0;
        exp_ex("t6_invalid_no_mispredict", 1'b0, 32'h80);

        next_cycle();
        ex_idle();
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor and EX-stage resolution checker; the predicting end of the branch-resolution path.
- In IF it looks up the fetch PC in a direct-mapped BHT/BTB and supplies pred_taken/pred_target.
- In EX it compares the resolved do_branch outcome and target against the prediction carried down the pipe. On a mismatch it raises mispredict with redirect_pc, and it trains the tables on every resolved branch or jal.

Parameters:
- XLEN, 32, PC/target width.
- IDX_W, 4, index bits; the table has 2^IDX_W entries and is indexed by pc[IDX_W+1:2].
- TAG_W, XLEN-IDX_W-2, tag width = pc[XLEN-1:IDX_W+2].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  predicted taken for if_pc
- pred_target  out  XLEN  predicted target; equals if_pc+4 when not taken
- ex_valid  in  1  EX holds a real (non-bubble, non-stalled) instruction
- ex_pc  in  XLEN  PC of the EX instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  jal
- ex_is_jalr  in  1  jalr
- ex_taken  in  1  resolved do_branch
- ex_target  in  XLEN  resolved target
- ex_pred_taken  in  1  pred_taken carried from IF
- ex_pred_target  in  XLEN  pred_target carried from IF
- mispredict  out  1  flush IF/ID and redirect
- redirect_pc  out  XLEN  correct next PC

Behaviour:
- Clocking/reset: single clock domain on clk; rst is synchronous, active-high.
- Reset state:
  - All valid bits cleared.
  - Counters set to 2'b01 (weakly not-taken); tags and targets are don't-care.
  - With if_pc stable, pred_taken=0 and pred_target=if_pc+4 in the cycle after reset.
  - mispredict=0 while ex_valid=0.
- Entry contents: valid, tag[TAG_W], ctr[2], target[XLEN].
- Prediction (combinational, zero latency from if_pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4 (mod 2^XLEN wrap).
- Check (combinational):
  - mispredict = ex_valid & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - jalr is never allocated, so a jalr always mispredicts unless a stale alias happened to predict the exact target.
- Update on the clk edge, when ex_valid & (ex_is_branch | ex_is_jal) & !rst:
  - Index hit: the counter saturates up if ex_taken, down otherwise (11 stays 11, 00 stays 00). The target is written with ex_target when ex_taken.
  - Index miss, ex_taken=1: allocate. valid=1, tag written, target=ex_target, ctr=2'b10.
  - Index miss, ex_taken=0: no allocation.
  - jal: ctr is forced to 2'b11 on both allocate and hit.
  - ex_is_jalr or a non-branch instruction: no table write.
- Simultaneous IF lookup and EX update to the same index: IF sees the pre-update value (no bypass).
- Aliasing: a tag mismatch on update replaces the entry only if ex_taken.
- rst asserted mid-operation wins over any update in that cycle.
- There is no pipeline state inside the block. Carrying ex_pred_* from IF to EX, and stall/flush gating of ex_valid, are the pipeline's responsibility.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds outputs stat_branches[31:0], stat_mispred[31:0] and stat_hits[31:0]:
  - stat_branches increments on each ex_valid & (branch|jal|jalr).
  - stat_mispred increments on each mispredict.
  - stat_hits increments on each IF lookup hit, counted only when the added input if_valid=1.
  - All three are cleared by rst and wrap at 2^32.
- When undefined, these ports, if_valid and the counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - The entry struct.
  - The XLEN default.
- One natural sub-module: bp_sat_counter, a 2-bit saturating next-state function (taken in, ctr in, ctr out), instantiated once in the update path.

Test Plan:
1. Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104. Then ex_valid=1, ex_pc=0x100, ex_is_branch=1, ex_taken=1, ex_target=0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80.
2. Counter saturation at pc 0x100: four taken updates then one not-taken → still predicted taken (11→10). A second not-taken → pred_taken=0, pred_target=0x104.
3. jal at 0x200 with target 0x400: first resolution mispredicts. Afterwards pred_taken=1, pred_target=0x400, and one not-taken-style update is impossible (jal always taken).
4. jalr at 0x300 with target 0x500, resolved twice → mispredict=1 both times, redirect_pc=0x500, and no entry is allocated (lookup of 0x300 is not taken).
5. Alias: pc 0x100 and 0x140 with IDX_W=4 share an index. Train 0x100 taken, then resolve 0x140 taken to 0x900 → lookup 0x100 misses (pred_target=0x104) and lookup 0x140 hits with target 0x900. Same-cycle lookup/update of 0x140 returns the old entry.
6. Drive a taken update with rst=1 in the same cycle → after release all lookups miss. Check ex_pc=0xFFFFFFFC not-taken → redirect_pc=0x00000000 (wrap).
